ascii_cell_mapper: RTL and testbench
====================================

# ascii_cell_mapper

Streaming grayscale-to-ASCII converter that averages each CELL_W×CELL_H pixel cell of the active VGA raster and emits one ASCII code per cell. It uses a 10-level brightness ramp with a frame-latched invert mode. It sits after the BMP/grayscale pixel path, driven by the VGA decoder's DE and x/y counters. Its output feeds the character-buffer writer.

## Interface
- CELL_W, 8, cell width in pixels; power of 2, ≥2
- CELL_H, 16, cell height in pixels; power of 2, ≥2
- H_ACTIVE, 640, active pixels per line; multiple of CELL_W
- COORD_W, 10, width of x_pixel/y_pixel
- clk  input  1  pixel clock
- rst_n  input  1  synchronous, active-low reset
- DE  input  1  display enable; pixel valid when high
- x_pixel  input  COORD_W  active-area column of current pixel
- y_pixel  input  COORD_W  active-area row of current pixel
- gray  input  8  pixel luminance, 0 = black
- invert  input  1  invert ramp; sampled once per frame
- char_valid  output  1  one-cycle strobe; char_* valid
- char_col  output  $clog2(H_ACTIVE/CELL_W)  cell column = x_pixel / CELL_W
- char_row  output  COORD_W-$clog2(CELL_H)  cell row = y_pixel / CELL_H
- ascii_out  output  8  mapped character code

## Operation
- COLS = H_ACTIVE/CELL_W column accumulators, each SUM_W = 8+log2(CELL_W)+log2(CELL_H) bits. Full-white sums cannot overflow.
- Each DE-high pixel, accumulator index x_pixel>>log2(CELL_W):
  - first pixel of cell (x%CELL_W==0 and y%CELL_H==0): acc = gray. Loads, does not add; stale data never leaks across cells or frames.
  - last pixel of cell (x%CELL_W==CELL_W-1 and y%CELL_H==CELL_H-1): total = acc+gray; emit; acc unchanged. It is reloaded at the next cell's first pixel.
  - otherwise: acc = acc + gray.
- DE low: no accumulator change, no emission.
- avg = total >> log2(CELL_W·CELL_H), truncating floor. Apply invert: lvl = inv_q ? 255-avg : avg.
- Ramp on lvl:
  - <26 '@'
  - <52 '%'
  - <78 '#'
  - <103 '*'
  - <129 '+'
  - <154 '='
  - <180 '-'
  - <205 ':'
  - <231 '.'
  - else ' ' (0x20)
- inv_q loads invert on the DE-high pixel at x=0,y=0. It is constant for the rest of the frame. A mid-frame invert change takes effect next frame.
- Accumulators are not reset by rst_n. The first-pixel load rule makes their reset value irrelevant.
- Partial cells (reset or DE gaps mid-cell) still emit at the cell's last pixel using whatever was accumulated since the last first-pixel load. Only cells whose first pixel was seen after reset are emitted. A per-column "armed" bit is cleared by reset and set at the first pixel.

## Timing
- Reset (rst_n low at clk edge):
  - char_valid=0, char_col=0, char_row=0, ascii_out=0x20
  - inv_q=0
  - all armed bits=0
- Latency: the last pixel of a cell is sampled at edge N. At edge N+1 char_valid=1 with ascii_out/char_col/char_row. char_valid returns to 0 at N+2 unless another cell completes.
- Throughput: at most one emission per CELL_W cycles. No backpressure; the consumer must accept every strobe.
- Between strobes, ascii_out/char_col/char_row hold their last values.
- Accumulator read-modify-write completes in one cycle. Consecutive pixels always hit different or the same column entry legally.
- Last pixel of cell (COLS-1, last row) at x=H_ACTIVE-1: emits normally. Index wrap to 0 on the next line is handled by the first-pixel/accumulate rules.
- Reset mid-cell: no emission for any column until that column sees a first pixel; then normal.

## Test plan
- Uniform frame gray=0, invert=0 → every cell emits '@' (0x40). 80 strobes per 16-line band; char_col 0..79, char_row increments per band.
- Uniform gray=100 → all '*'. Uniform gray=255 → all ' ' (0x20).
- One 8×16 cell with left 4 columns 0 and right 4 columns 255 → total 16320, avg 127 → '+'. Strobe exactly 1 cycle after pixel (x=7,y=15).
- invert=1 held through frame start, gray=0 → ' '. invert toggled to 0 mid-frame → ' ' persists until the next frame, then '@'.
- DE low for 8 cycles mid-line with x/y frozen → no strobes, no accumulation change. Output of the affected cell is the same as an uninterrupted run.
- Assert rst_n low at (x=3,y=5) for 2 cycles → all outputs at reset values. No strobes until band row 1 (y=31). Cells of band 1 map correctly.

Source files
------------

// File: rtl/ascii_cell_mapper.sv
// Streaming grayscale-to-ASCII cell mapper: averages each CELL_W x CELL_H cell of the
// active raster and emits one ramp character per cell, with a frame-latched invert.
module ascii_cell_mapper #(
  parameter int CELL_W   = 8,
  parameter int CELL_H   = 16,
  parameter int H_ACTIVE = 640,
  parameter int COORD_W  = 10,
  localparam int COL_W   = $clog2(H_ACTIVE / CELL_W),
  localparam int ROW_W   = COORD_W - $clog2(CELL_H)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               DE,
  input  logic [COORD_W-1:0] x_pixel,
  input  logic [COORD_W-1:0] y_pixel,
  input  logic [7:0]         gray,
  input  logic               invert,
  output logic               char_valid,
  output logic [COL_W-1:0]   char_col,
  output logic [ROW_W-1:0]   char_row,
  output logic [7:0]         ascii_out
);

  localparam int XW    = $clog2(CELL_W);
  localparam int YW    = $clog2(CELL_H);
  localparam int COLS  = H_ACTIVE / CELL_W;
  localparam int SUM_W = 8 + XW + YW;

  function automatic logic [7:0] ramp_char(input logic [7:0] lvl);
    logic [7:0] c;
    if (lvl < 8'd26)       c = 8'h40;
    else if (lvl < 8'd52)  c = 8'h25;
    else if (lvl < 8'd78)  c = 8'h23;
    else if (lvl < 8'd103) c = 8'h2A;
    else if (lvl < 8'd129) c = 8'h2B;
    else if (lvl < 8'd154) c = 8'h3D;
    else if (lvl < 8'd180) c = 8'h2D;
    else if (lvl < 8'd205) c = 8'h3A;
    else if (lvl < 8'd231) c = 8'h2E;
    else                   c = 8'h20;
    return c;
  endfunction

  logic [SUM_W-1:0] acc_q [COLS];
  logic [COLS-1:0]  armed_q, armed_d;
  logic             inv_q, inv_d;
  logic             char_valid_q, char_valid_d;
  logic [COL_W-1:0] char_col_q, char_col_d;
  logic [ROW_W-1:0] char_row_q, char_row_d;
  logic [7:0]       ascii_q, ascii_d;

  logic [COL_W-1:0] idx_s;
  logic             first_s, last_s, origin_s;
  logic [SUM_W-1:0] sum_s, acc_wdata_s;
  logic             acc_we_s;
  logic [7:0]       avg_s, lvl_s;

  assign idx_s    = x_pixel[XW +: COL_W];
  assign first_s  = (x_pixel[XW-1:0] == {XW{1'b0}}) && (y_pixel[YW-1:0] == {YW{1'b0}});
  assign last_s   = (&x_pixel[XW-1:0]) && (&y_pixel[YW-1:0]);
  assign origin_s = (x_pixel == {COORD_W{1'b0}}) && (y_pixel == {COORD_W{1'b0}});
  assign sum_s    = acc_q[idx_s] + {{(SUM_W-8){1'b0}}, gray};
  // The shifted-out low bits implement the truncating divide by the cell area.
  assign avg_s    = sum_s[SUM_W-1 -: 8];
  assign lvl_s    = inv_q ? (8'd255 - avg_s) : avg_s;

  // Per-pixel decode: load, accumulate or emit for the addressed column.
  always_comb begin
    armed_d      = armed_q;
    inv_d        = inv_q;
    char_valid_d = 1'b0;
    char_col_d   = char_col_q;
    char_row_d   = char_row_q;
    ascii_d      = ascii_q;
    acc_we_s     = 1'b0;
    acc_wdata_s  = sum_s;
    if (DE && first_s) begin
      acc_we_s       = 1'b1;
      acc_wdata_s    = {{(SUM_W-8){1'b0}}, gray};
      armed_d[idx_s] = 1'b1;
      if (origin_s) begin
        inv_d = invert;
      end else begin
        inv_d = inv_q;
      end
    end else if (DE && last_s) begin
      if (armed_q[idx_s]) begin
        char_valid_d = 1'b1;
        char_col_d   = idx_s;
        char_row_d   = y_pixel[COORD_W-1:YW];
        ascii_d      = ramp_char(lvl_s);
      end else begin
        char_valid_d = 1'b0;
      end
    end else if (DE) begin
      acc_we_s = 1'b1;
    end else begin
      acc_we_s = 1'b0;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_q      <= {COLS{1'b0}};
      inv_q        <= 1'b0;
      char_valid_q <= 1'b0;
      char_col_q   <= {COL_W{1'b0}};
      char_row_q   <= {ROW_W{1'b0}};
      ascii_q      <= 8'h20;
    end else begin
      armed_q      <= armed_d;
      inv_q        <= inv_d;
      char_valid_q <= char_valid_d;
      char_col_q   <= char_col_d;
      char_row_q   <= char_row_d;
      ascii_q      <= ascii_d;
    end
  end

  // Column accumulators; deliberately unreset since the first pixel of a cell reloads them.
  always_ff @(posedge clk) begin
    if (acc_we_s) begin
      acc_q[idx_s] <= acc_wdata_s;
    end
  end

  assign char_valid = char_valid_q;
  assign char_col   = char_col_q;
  assign char_row   = char_row_q;
  assign ascii_out  = ascii_q;

endmodule

// File: tb/tb_ascii_cell_mapper.sv
// Directed self-checking bench for ascii_cell_mapper on a reduced 128x32 raster.
module tb_ascii_cell_mapper;

  localparam int CW   = 8;
  localparam int CH   = 16;
  localparam int HA   = 128;
  localparam int VA   = 32;
  localparam int CRDW = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            de;
  logic [CRDW-1:0] x_pixel, y_pixel;
  logic [7:0]      gray;
  logic            invert;
  logic            char_valid;
  logic [3:0]      char_col;
  logic [5:0]      char_row;
  logic [7:0]      ascii_out;

  ascii_cell_mapper #(
    .CELL_W(CW), .CELL_H(CH), .H_ACTIVE(HA), .COORD_W(CRDW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .DE(de), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .gray(gray), .invert(invert), .char_valid(char_valid), .char_col(char_col),
    .char_row(char_row), .ascii_out(ascii_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int stamp;
    int col;
    int row;
    int ch;
  } strobe_t;

  strobe_t got_q[$];
  strobe_t exp_q[$];
  strobe_t mon_s;
  strobe_t exp_s;

  // Capture every strobe with the cycle it became visible.
  always @(negedge clk) begin
    if (char_valid === 1'b1) begin
      mon_s.stamp = cyc;
      mon_s.col   = int'(char_col);
      mon_s.row   = int'(char_row);
      mon_s.ch    = int'(ascii_out);
      got_q.push_back(mon_s);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int g_const  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gray_of(input int mode, input int x, input int y);
    case (mode)
      0:       return g_const;
      1:       return (x < 8 && y < 16 && (x % 8) >= 4) ? 255 : 0;
      2:       return (x * 7 + y * 13) % 256;
      default: return 0;
    endcase
  endfunction

  function automatic int ramp_ref(input int lvl);
    if (lvl < 26)  return 8'h40;
    if (lvl < 52)  return 8'h25;
    if (lvl < 78)  return 8'h23;
    if (lvl < 103) return 8'h2A;
    if (lvl < 129) return 8'h2B;
    if (lvl < 154) return 8'h3D;
    if (lvl < 180) return 8'h2D;
    if (lvl < 205) return 8'h3A;
    if (lvl < 231) return 8'h2E;
    return 8'h20;
  endfunction

  function automatic int cell_char(input int mode, input int col, input int row, input int inv);
    int sum;
    int avg;
    sum = 0;
    for (int yy = 0; yy < CH; yy++)
      for (int xx = 0; xx < CW; xx++)
        sum += gray_of(mode, col * CW + xx, row * CH + yy);
    avg = sum / (CW * CH);
    return ramp_ref(inv != 0 ? 255 - avg : avg);
  endfunction

  task automatic drive(input logic de_v, input int x, input int y, input int g,
                       input logic inv_v, input logic rst_v);
    @(posedge clk);
    #1;
    rst_n   = rst_v;
    de      = de_v;
    x_pixel = x[CRDW-1:0];
    y_pixel = y[CRDW-1:0];
    gray    = g[7:0];
    invert  = inv_v;
  endtask

  task automatic run_frame(input int mode, input logic inv_a, input logic inv_b,
                           input bit gap, input bit rst_mid, input string name);
    logic inv_v;
    logic rst_v;
    int   n;
    got_q.delete();
    exp_q.delete();
    for (int y = 0; y < VA; y++) begin
      inv_v = (y < 16) ? inv_a : inv_b;
      for (int x = 0; x < HA; x++) begin
        if (gap && x == 20 && y == 5)
          repeat (8) drive(1'b0, x, y, 255, inv_v, 1'b1);
        rst_v = !(rst_mid && y == 5 && (x == 3 || x == 4));
        drive(1'b1, x, y, gray_of(mode, x, y), inv_v, rst_v);
        if (rst_mid && y == 5 && x == 4) begin
          check({name, "_rst_valid"}, 32'(char_valid), 32'd0);
          check({name, "_rst_col"},   32'(char_col),   32'd0);
          check({name, "_rst_row"},   32'(char_row),   32'd0);
          check({name, "_rst_ascii"}, 32'(ascii_out),  32'h20);
        end
        if (x % CW == CW - 1 && y % CH == CH - 1 && !(rst_mid && y < CH)) begin
          exp_s.stamp = cyc + 1;
          exp_s.col   = x / CW;
          exp_s.row   = y / CH;
          exp_s.ch    = cell_char(mode, x / CW, y / CH, int'(inv_a));
          exp_q.push_back(exp_s);
        end
      end
      repeat (2) drive(1'b0, 0, y, 0, inv_v, 1'b1);
    end
    repeat (3) drive(1'b0, 0, 0, 0, inv_b, 1'b1);
    check({name, "_nstrobe"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_stamp%0d", name, i), 32'(got_q[i].stamp), 32'(exp_q[i].stamp));
      check($sformatf("%s_col%0d", name, i),   32'(got_q[i].col),   32'(exp_q[i].col));
      check($sformatf("%s_row%0d", name, i),   32'(got_q[i].row),   32'(exp_q[i].row));
      check($sformatf("%s_char%0d", name, i),  32'(got_q[i].ch),    32'(exp_q[i].ch));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    de      = 1'b0;
    x_pixel = '0;
    y_pixel = '0;
    gray    = 8'd0;
    invert  = 1'b0;
    repeat (3) drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("reset_valid", 32'(char_valid), 32'd0);
    check("reset_col",   32'(char_col),   32'd0);
    check("reset_row",   32'(char_row),   32'd0);
    check("reset_ascii", 32'(ascii_out),  32'h20);

    g_const = 0;
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, "black");
    check("black_first_char", 32'(cell_char(0, 0, 0, 0)), 32'h40);
    g_const = 100;
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, "gray100");
    g_const = 255;
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, "white");
    run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, "halfcell");
    g_const = 0;
    run_frame(0, 1'b1, 1'b0, 1'b0, 1'b0, "inv_held");
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, "inv_next");
    run_frame(2, 1'b0, 1'b0, 1'b1, 1'b0, "de_gap");
    run_frame(2, 1'b0, 1'b0, 1'b0, 1'b1, "rst_mid");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
